// File: rtl/stack_bus_pkg.sv
// Shared definitions for the stack-machine data bus: MMIO register offsets,
// the filler word returned for unmapped reads, and the address-decode regions.
package stack_bus_pkg;

    localparam logic [1:0]  SEG1_OFS      = 2'd0;
    localparam logic [1:0]  SEG2_OFS      = 2'd1;
    localparam logic [1:0]  CYC_OFS       = 2'd2;
    localparam logic [1:0]  WRC_OFS       = 2'd3;
    localparam logic [15:0] UNMAPPED_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        MMIO     = 2'd1,
        UNMAPPED = 2'd2
    } bus_region_e;

endpackage

// File: rtl/bus_read_pipe.sv
// Fixed-depth delay line for read data. The output is the input delayed by
// DEPTH rising edges; every stage clears to zero on reset.
module bus_read_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; reset flushes the whole line to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/stack_ram_responder.sv
// Memory-side responder for the stack-machine RAM port.
// Backs a word-addressed stack RAM and returns read data READ_LATENCY
// cycles after the address (legal range 1..4). Defining STACK_RAM_MMIO_EN
// adds a 4-word MMIO window at MMIO_BASE (SEG1, SEG2, cycle counter, write
// counter) and a sticky bus_err flag for unmapped accesses; without it every
// address wraps onto the RAM and the MMIO outputs are tied to zero.
//
// Bus protocol: there is no handshake. Every cycle is one access; the
// address (and data/wren_ram for writes) sampled at a rising edge produces
// its read data on q_ram READ_LATENCY edges later, one result per cycle in
// order. A read to the address being written in the same cycle returns the
// new data (write-first).
module stack_ram_responder
    import stack_bus_pkg::*;
#(
    parameter int          DEPTH_LOG2   = 8,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] MMIO_BASE    = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_ram,
    input  logic [15:0] data_ram,
    input  logic        wren_ram,
    output logic [15:0] q_ram,
    output logic [15:0] SEG1,
    output logic [15:0] SEG2,
    output logic        bus_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ram_idx;
    bus_region_e           region;
    logic                  ram_we;
    logic [15:0]           ram_rd;
    logic [15:0]           rd_data;

    assign ram_idx = address_ram[DEPTH_LOG2-1:0];
    assign ram_we  = wren_ram && (region == RAM);
    // Write-first: a write to the addressed word is what this cycle reads.
    assign ram_rd  = ram_we ? data_ram : mem[ram_idx];

    // Stack RAM storage; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= data_ram;
        end
    end

`ifdef STACK_RAM_MMIO_EN
    logic [15:0] mmio_ofs;
    logic [15:0] seg1_q;
    logic [15:0] seg2_q;
    logic [15:0] cyc_cnt;
    logic [15:0] wr_cnt;
    logic        err_q;
    logic        mmio_we;

    assign mmio_ofs = address_ram - MMIO_BASE;
    assign mmio_we  = wren_ram && (region == MMIO);

    // Decode the current address into RAM, MMIO window or unmapped space.
    always_comb begin
        region = UNMAPPED;
        if (32'(address_ram) < DEPTH) begin
            region = RAM;
        end else if ((address_ram >= MMIO_BASE) && (mmio_ofs < 16'd4)) begin
            region = MMIO;
        end
    end

    // MMIO registers, free-running counters and the sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg1_q  <= '0;
            seg2_q  <= '0;
            cyc_cnt <= '0;
            wr_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (mmio_we && (mmio_ofs[1:0] == SEG1_OFS)) begin
                seg1_q <= data_ram;
            end
            if (mmio_we && (mmio_ofs[1:0] == SEG2_OFS)) begin
                seg2_q <= data_ram;
            end
            // Clear-by-write takes priority over the per-cycle increment.
            if (mmio_we && (mmio_ofs[1:0] == CYC_OFS)) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
            if (ram_we) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (region == UNMAPPED) begin
                err_q <= 1'b1;
            end
        end
    end

    // Form this cycle's read word from the decoded region.
    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (region)
            RAM: rd_data = ram_rd;
            MMIO: begin
                case (mmio_ofs[1:0])
                    SEG1_OFS: rd_data = seg1_q;
                    SEG2_OFS: rd_data = seg2_q;
                    CYC_OFS:  rd_data = cyc_cnt;
                    default:  rd_data = wr_cnt;
                endcase
            end
            default: rd_data = UNMAPPED_DATA;
        endcase
    end

    assign SEG1    = seg1_q;
    assign SEG2    = seg2_q;
    assign bus_err = err_q;
`else
    // Upper address bits are deliberately ignored: the RAM wraps around.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_ram;

    assign region  = RAM;
    assign rd_data = ram_rd;
    assign SEG1    = '0;
    assign SEG2    = '0;
    assign bus_err = 1'b0;
`endif

    bus_read_pipe #(
        .WIDTH (16),
        .DEPTH (READ_LATENCY)
    ) u_read_pipe (
        .clock (clock),
        .reset (reset),
        .din   (rd_data),
        .dout  (q_ram)
    );

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed bench for stack_ram_responder (READ_LATENCY = 2, DEPTH_LOG2 = 8).
// MMIO checks are compiled when STACK_RAM_MMIO_EN is defined; otherwise the
// wrap-around and tied-off output checks run.
module tb_stack_ram_responder;

    logic        clock;
    logic        reset;
    logic [15:0] address_ram;
    logic [15:0] data_ram;
    logic        wren_ram;
    logic [15:0] q_ram;
    logic [15:0] SEG1;
    logic [15:0] SEG2;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    stack_ram_responder #(
        .DEPTH_LOG2   (8),
        .READ_LATENCY (2),
        .MMIO_BASE    (16'hFF00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_ram (address_ram),
        .data_ram    (data_ram),
        .wren_ram    (wren_ram),
        .q_ram       (q_ram),
        .SEG1        (SEG1),
        .SEG2        (SEG2),
        .bus_err     (bus_err)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        address_ram = 16'h0000;
        data_ram    = 16'h0000;
        wren_ram    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_q", q_ram, 16'h0000);
        check("rst_seg1", SEG1, 16'h0000);
        check("rst_seg2", SEG2, 16'h0000);
        check("rst_err", {15'd0, bus_err}, 16'h0000);

        // Write 1234 to addr 3; result of that access lands two edges later.
        address_ram = 16'h0003; data_ram = 16'h1234; wren_ram = 1'b1; reset = 1'b0;
        tick();
        check("lat_pre", q_ram, 16'h0000);
        wren_ram = 1'b0;
        tick();
        check("rd3", q_ram, 16'h1234);

        // Write-first: write AAAA to 5 reads back AAAA.
        address_ram = 16'h0005; data_ram = 16'hAAAA; wren_ram = 1'b1;
        tick();
        wren_ram = 1'b0; address_ram = 16'h0003;
        tick();
        check("wr_first5", q_ram, 16'hAAAA);
        tick();
        check("rd3_again", q_ram, 16'h1234);

        // Back-to-back reads after writing 10,20,30.
        wren_ram = 1'b1;
        address_ram = 16'h0000; data_ram = 16'd10; tick();
        address_ram = 16'h0001; data_ram = 16'd20; tick();
        address_ram = 16'h0002; data_ram = 16'd30; tick();
        wren_ram = 1'b0;
        address_ram = 16'h0000; tick();
        address_ram = 16'h0001; tick();
        check("b2b_0", q_ram, 16'd10);
        address_ram = 16'h0002; tick();
        check("b2b_1", q_ram, 16'd20);
        address_ram = 16'h0003; tick();
        check("b2b_2", q_ram, 16'd30);

`ifdef STACK_RAM_MMIO_EN
        // SEG registers.
        address_ram = 16'hFF00; data_ram = 16'h0042; wren_ram = 1'b1;
        tick();
        check("seg1_wr", SEG1, 16'h0042);
        address_ram = 16'hFF01; data_ram = 16'h5555;
        tick();
        check("seg2_wr", SEG2, 16'h5555);
        check("seg1_hold", SEG1, 16'h0042);
        wren_ram = 1'b0; address_ram = 16'hFF00;
        tick();
        tick();
        check("seg1_rd", q_ram, 16'h0042);

        // Cycle counter: clear by write, then reads 0, 1, 2.
        address_ram = 16'hFF02; data_ram = 16'hFFFF; wren_ram = 1'b1;
        tick();
        wren_ram = 1'b0;
        tick();
        tick();
        check("cyc0", q_ram, 16'h0000);
        tick();
        check("cyc1", q_ram, 16'h0001);
        tick();
        check("cyc2", q_ram, 16'h0002);

        // Reset clears SEG and counters; three RAM writes then read FF03.
        reset = 1'b1;
        #1;
        check("rst2_seg1", SEG1, 16'h0000);
        check("rst2_q", q_ram, 16'h0000);
        tick();
        reset = 1'b0;
        wren_ram = 1'b1;
        address_ram = 16'h0006; data_ram = 16'h0001; tick();
        address_ram = 16'h0007; data_ram = 16'h0002; tick();
        address_ram = 16'h0008; data_ram = 16'h0003; tick();
        wren_ram = 1'b0; address_ram = 16'hFF03;
        tick();
        tick();
        check("wrc3", q_ram, 16'h0003);

        // Unmapped access: DEAD and sticky bus_err.
        address_ram = 16'h8000;
        tick();
        check("err_set", {15'd0, bus_err}, 16'h0001);
        address_ram = 16'h0003;
        tick();
        check("unmapped_rd", q_ram, 16'hDEAD);
        tick();
        tick();
        check("err_hold", {15'd0, bus_err}, 16'h0001);
        check("rd3_after_err", q_ram, 16'h1234);

        // Reset mid-read clears q_ram and bus_err at once; RAM is retained.
        reset = 1'b1;
        #1;
        check("rst3_q", q_ram, 16'h0000);
        check("rst3_err", {15'd0, bus_err}, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rd3_post_rst", q_ram, 16'h1234);
`else
        // Without MMIO the address wraps modulo 256.
        address_ram = 16'h0105; data_ram = 16'h7777; wren_ram = 1'b1;
        tick();
        wren_ram = 1'b0; address_ram = 16'h0005;
        tick();
        tick();
        check("wrap_rd5", q_ram, 16'h7777);
        check("seg1_tied", SEG1, 16'h0000);
        check("err_tied", {15'd0, bus_err}, 16'h0000);
        address_ram = 16'h8003;
        tick();
        tick();
        check("wrap_rd8003", q_ram, 16'h1234);

        // Reset mid-read: q_ram clears at once, RAM retained.
        address_ram = 16'h0005;
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_q", q_ram, 16'h0000);
        tick();
        reset = 1'b0; address_ram = 16'h0003;
        tick();
        check("post_rst_flush", q_ram, 16'h0000);
        tick();
        check("rd3_post_rst", q_ram, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
